// File: rtl/pcs_pkg.sv
// rtl/pcs_pkg.sv - shared 10GBASE-R PCS constants and types
//
// Purpose: block geometry and sync-header encodings used across the PCS
//          receive path, plus the gearbox half selector type.
// Ports:   none (package).
package pcs_pkg;

   localparam int BLOCK_WIDTH    = 66;
   localparam int HEADER_WIDTH   = 2;
   localparam int PCS_DATA_WIDTH = 32;

   localparam logic [HEADER_WIDTH-1:0] SYNC_DATA = 2'b01;
   localparam logic [HEADER_WIDTH-1:0] SYNC_CTRL = 2'b10;

   // Which half of the 66-bit block the gearbox emits next.
   typedef enum logic {
      HALF_0 = 1'b0,
      HALF_1 = 1'b1
   } half_e;

   function automatic logic is_sync_header(input logic [HEADER_WIDTH-1:0] hdr);
      return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
   endfunction

endpackage

// File: rtl/rx_gearbox_if.sv
// rtl/rx_gearbox_if.sv - block-half output bundle of the receive gearbox
//
// Purpose: groups the gearbox output stream (payload half, sync header and
//          their qualifiers) so it can be passed to the block-lock / decoder
//          stage as one port.
// Ports:   master - driven by rx_gearbox
//          slave  - consumed by the downstream PCS logic
interface rx_gearbox_if #(
   parameter int DATA_WIDTH = 32
);
   import pcs_pkg::*;

   logic [DATA_WIDTH-1:0]   o_data;          // block bits 33:2 (half 0) or 65:34 (half 1)
   logic [HEADER_WIDTH-1:0] o_header;        // block bits 1:0, [0] received first
   logic                    o_valid;         // o_data holds a half this cycle
   logic                    o_header_valid;  // o_header valid, only with half 0

   modport master (
      output o_data,
      output o_header,
      output o_valid,
      output o_header_valid
   );

   modport slave (
      input o_data,
      input o_header,
      input o_valid,
      input o_header_valid
   );

endinterface

// File: rtl/rx_gearbox.sv
// rtl/rx_gearbox.sv - 32:66 receive gearbox with single-bit slip
//
// Purpose: packs the 32-bit transceiver stream into 66-bit blocks emitted as
//          two 32-bit halves, the sync header travelling with half 0. A slip
//          request drops one received bit before the next half 0.
// Ports:   i_clk   - PCS receive clock
//          i_reset - synchronous active-high reset
//          i_data  - received bits, bit 0 first, one word every cycle
//          i_slip  - slip request pulse from block lock
//          out_if  - o_data / o_header / o_valid / o_header_valid
module rx_gearbox
   import pcs_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int BUF_WIDTH  = 128
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_slip,
   rx_gearbox_if.master          out_if
);

   localparam int FILL_W = $clog2(BUF_WIDTH + 1);

   localparam logic [FILL_W-1:0] NEED_H0      = FILL_W'(HEADER_WIDTH + DATA_WIDTH);
   localparam logic [FILL_W-1:0] NEED_H0_SLIP = FILL_W'(HEADER_WIDTH + DATA_WIDTH + 1);
   localparam logic [FILL_W-1:0] NEED_H1      = FILL_W'(DATA_WIDTH);
   localparam logic [FILL_W-1:0] WORD_BITS    = FILL_W'(DATA_WIDTH);

   logic [BUF_WIDTH-1:0]    buf_q, buf_d, buf_shifted;
   logic [FILL_W-1:0]       fill_q, fill_d, fill_base, need, skip;
   half_e                   half_q, half_d;
   logic                    slip_q, slip_d;
   logic                    emit;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic [HEADER_WIDTH-1:0] header_q, header_d;
   logic                    valid_q, valid_d;
   logic                    hvalid_q, hvalid_d;

   always_comb begin
      need        = NEED_H1;
      emit        = 1'b0;
      skip        = '0;
      buf_shifted = buf_q;
      fill_base   = fill_q;
      buf_d       = buf_q;
      fill_d      = fill_q;
      half_d      = half_q;
      slip_d      = slip_q | i_slip;   // a pending slip absorbs further requests
      data_d      = data_q;
      header_d    = header_q;
      valid_d     = 1'b0;
      hvalid_d    = 1'b0;

      if (half_q == HALF_0) begin
         need = slip_q ? NEED_H0_SLIP : NEED_H0;
      end

      // Decide on the registered fill only; the incoming word lands after the
      // consumed bits are shifted out, which keeps the buffer below 99 bits.
      emit = (fill_q >= need);
      if (emit) begin
         buf_shifted = buf_q >> need;
         fill_base   = fill_q - need;
      end
      buf_d  = buf_shifted | (BUF_WIDTH'(i_data) << fill_base);
      fill_d = fill_base + WORD_BITS;

      if (emit) begin
         valid_d = 1'b1;
         if (half_q == HALF_0) begin
            skip     = slip_q ? FILL_W'(1) : FILL_W'(0);
            header_d = buf_q[skip +: HEADER_WIDTH];
            data_d   = buf_q[skip + FILL_W'(HEADER_WIDTH) +: DATA_WIDTH];
            hvalid_d = 1'b1;
            half_d   = HALF_1;
            // This emit executes the pending slip; a request arriving now
            // becomes the next pending slip.
            slip_d   = i_slip;
         end else begin
            data_d = buf_q[DATA_WIDTH-1:0];
            half_d = HALF_0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         buf_q    <= '0;
         fill_q   <= '0;
         half_q   <= HALF_0;
         slip_q   <= 1'b0;
         data_q   <= '0;
         header_q <= '0;
         valid_q  <= 1'b0;
         hvalid_q <= 1'b0;
      end else begin
         buf_q    <= buf_d;
         fill_q   <= fill_d;
         half_q   <= half_d;
         slip_q   <= slip_d;
         data_q   <= data_d;
         header_q <= header_d;
         valid_q  <= valid_d;
         hvalid_q <= hvalid_d;
      end
   end

   assign out_if.o_data         = data_q;
   assign out_if.o_header       = header_q;
   assign out_if.o_valid        = valid_q;
   assign out_if.o_header_valid = hvalid_q;

endmodule

// File: tb/tb_rx_gearbox.sv
// tb/tb_rx_gearbox.sv - directed self-checking bench for rx_gearbox
module tb_rx_gearbox;

   logic        i_clk;
   logic        i_reset;
   logic [31:0] i_data;
   logic        i_slip;

   rx_gearbox_if #(.DATA_WIDTH(32)) gb_if ();

   rx_gearbox #(
      .DATA_WIDTH(32),
      .BUF_WIDTH (128)
   ) dut (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .i_data (i_data),
      .i_slip (i_slip),
      .out_if (gb_if)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_vec  = 0;
   int n_miss = 0;

   // Serial source: `lead` zero bits, then back-to-back 66-bit blocks.
   int spos = 0;
   int lead = 0;
   int mode = 0;   // 0: constant block, 1: pseudo-random blocks

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [65:0] blk_for(input int k);
      logic [31:0] h, g;
      if (mode == 0) return {64'h0123_4567_89AB_CDEF, 2'b01};
      h = 32'(k) * 32'h9E37_79B9;
      g = h * 32'h85EB_CA6B;
      g = g ^ (g >> 13);
      return {h ^ g, g ^ 32'hC2B2_AE35, (h[17] ? 2'b01 : 2'b10)};
   endfunction

   task automatic next_word(output logic [31:0] w);
      logic [65:0] b;
      int idx;
      for (int i = 0; i < 32; i++) begin
         if (spos < lead) begin
            w[i] = 1'b0;
         end else begin
            idx  = spos - lead;
            b    = blk_for(idx / 66);
            w[i] = b[idx % 66];
         end
         spos++;
      end
   endtask

   // Drive one cycle; outputs are observed 1 time unit after the edge.
   task automatic cyc();
      logic [31:0] w;
      if (i_reset) begin
         spos   = 0;
         i_data = '0;
      end else begin
         next_word(w);
         i_data = w;
      end
      @(posedge i_clk);
      #1;
   endtask

   task automatic wait_hv(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (gb_if.o_header_valid) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   // Checks an aligned constant-block stream over n cycles.
   task automatic scan_aligned(input int n, output int errs, output int nval);
      errs = 0;
      nval = 0;
      for (int c = 0; c < n; c++) begin
         cyc();
         if (gb_if.o_valid) begin
            nval++;
            if (gb_if.o_header_valid) begin
               if (gb_if.o_header !== 2'b01 || gb_if.o_data !== 32'h89AB_CDEF) errs++;
            end else if (gb_if.o_data !== 32'h0123_4567) begin
               errs++;
            end
         end
      end
   endtask

   task automatic do_reset(input int new_lead, input int new_mode);
      i_reset = 1'b1;
      i_slip  = 1'b0;
      lead    = new_lead;
      mode    = new_mode;
      cyc();
      cyc();
      i_reset = 1'b0;
   endtask

   initial begin
      int  nval, errs, alt_err, gap_err, last_stall, good, slips, extra;
      bit  prev_hv, ok, locked;
      int  post;

      i_reset = 1'b1;
      i_slip  = 1'b0;
      i_data  = '0;

      // Reset state
      do_reset(0, 0);
      check("rst_valid",  gb_if.o_valid, 0);
      check("rst_hvalid", gb_if.o_header_valid, 0);
      check("rst_header", gb_if.o_header, 0);
      check("rst_data",   gb_if.o_data, 0);

      // Aligned stream, first halves
      cyc(); check("c1_valid", gb_if.o_valid, 0);
      cyc(); check("c2_valid", gb_if.o_valid, 0);
      cyc();
      check("c3_valid",  gb_if.o_valid, 1);
      check("c3_hvalid", gb_if.o_header_valid, 1);
      check("c3_header", gb_if.o_header, 2'b01);
      check("c3_data",   gb_if.o_data, 32'h89AB_CDEF);
      cyc();
      check("c4_valid",  gb_if.o_valid, 1);
      check("c4_hvalid", gb_if.o_header_valid, 0);
      check("c4_data",   gb_if.o_data, 32'h0123_4567);

      // Steady state: 330 cycles, one stall every 33
      nval = 0; errs = 0; alt_err = 0; gap_err = 0; last_stall = -1; prev_hv = 1'b0;
      for (int c = 0; c < 330; c++) begin
         cyc();
         if (gb_if.o_valid) begin
            nval++;
            if (gb_if.o_header_valid == prev_hv) alt_err++;
            prev_hv = gb_if.o_header_valid;
            if (gb_if.o_header_valid) begin
               if (gb_if.o_header !== 2'b01 || gb_if.o_data !== 32'h89AB_CDEF) errs++;
            end else if (gb_if.o_data !== 32'h0123_4567) begin
               errs++;
            end
         end else begin
            if (last_stall >= 0 && (c - last_stall) != 33) gap_err++;
            last_stall = c;
         end
      end
      check("steady_nvalid",  nval, 320);
      check("steady_alt",     alt_err, 0);
      check("steady_gap",     gap_err, 0);
      check("steady_payload", errs, 0);

      // Reset mid-stream for one cycle
      i_reset = 1'b1;
      cyc();
      check("mrst_valid",  gb_if.o_valid, 0);
      check("mrst_hvalid", gb_if.o_header_valid, 0);
      check("mrst_header", gb_if.o_header, 0);
      check("mrst_data",   gb_if.o_data, 0);
      i_reset = 1'b0;
      cyc(); check("mrst_c1_valid", gb_if.o_valid, 0);
      cyc(); check("mrst_c2_valid", gb_if.o_valid, 0);
      cyc();
      check("mrst_c3_valid",  gb_if.o_valid, 1);
      check("mrst_c3_header", gb_if.o_header, 2'b01);
      check("mrst_c3_data",   gb_if.o_data, 32'h89AB_CDEF);

      // Stream offset by 5 bits, recovered with 5 slips
      do_reset(5, 0);
      cyc(); cyc(); cyc();
      check("off5_hvalid", gb_if.o_header_valid, 1);
      check("off5_header", gb_if.o_header, 2'b00);
      for (int s = 0; s < 5; s++) begin
         i_slip = 1'b1; cyc();
         i_slip = 1'b0; cyc(); cyc(); cyc();
      end
      for (int c = 0; c < 10; c++) cyc();
      scan_aligned(66, errs, nval);
      check("off5_nvalid",  nval, 64);
      check("off5_payload", errs, 0);

      // Two back-to-back slip pulses: one half-0 emit apart, so one bit only
      do_reset(0, 0);
      cyc(); cyc();
      i_slip = 1'b1; cyc();
      i_slip = 1'b1; cyc();
      i_slip = 1'b0;
      wait_hv(ok);
      wait_hv(ok);
      check("dslip_found",  ok, 1);
      check("dslip_header", gb_if.o_header, 2'b10);
      check("dslip_data0",  gb_if.o_data, 32'hC4D5_E6F7);
      cyc();
      check("dslip_valid1", gb_if.o_valid, 1);
      check("dslip_data1",  gb_if.o_data, 32'h8091_A2B3);

      // Loopback with a simple block-lock model
      do_reset($urandom_range(0, 65), 1);
      good = 0; slips = 0; extra = 0; locked = 1'b0; post = 0;
      for (int c = 0; c < 3000; c++) begin
         cyc();
         i_slip = 1'b0;
         if (locked) post++;
         if (gb_if.o_header_valid) begin
            if (gb_if.o_header == 2'b01 || gb_if.o_header == 2'b10) begin
               good++;
               if (good >= 64) locked = 1'b1;
            end else begin
               good   = 0;
               i_slip = 1'b1;
               if (locked) extra++;
               else slips++;
            end
         end
         if (locked && post >= 200) break;
      end
      i_slip = 1'b0;
      check("loop_locked", locked, 1);
      check("loop_slips_le66", (slips <= 66), 1);
      check("loop_extra_slips", extra, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
